// File: rtl/nvram_pkg.sv
// Shared types for the NVRAM shadow controller: copy-engine states and depth helper.
package nvram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    RECALL,
    FINISH
  } eng_state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/nvram_dp_ram.sv
// Dual-port synchronous RAM, DATA_W x 2^ADDR_W, registered read-before-write on both ports.
module nvram_dp_ram
  import nvram_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic              i_a_write,
  input  logic [DATA_W-1:0] i_a_data,
  output logic [DATA_W-1:0] o_a_q,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic              i_b_write,
  input  logic [DATA_W-1:0] i_b_data,
  output logic [DATA_W-1:0] o_b_q
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the storage array has no reset; its contents must survive reset (non-volatile model).
  // Both ports write from one process; the controller never lets them hit the same word together.
  always_ff @(posedge clk) begin
    if (i_a_write) r_mem[i_a_addr] <= i_a_data;
    if (i_b_write) r_mem[i_b_addr] <= i_b_data;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_a_q <= '0;
      o_b_q <= '0;
    end else begin
      o_a_q <= r_mem[i_a_addr];
      o_b_q <= r_mem[i_b_addr];
    end
  end

endmodule

// File: rtl/nvram_shadow_ctrl.sv
// Working RAM + shadow RAM with STORE/RECALL copy engine and dirty tracking.
// Optional host port on the shadow array is enabled by defining NVRAM_HOST_PORT_EN.
module nvram_shadow_ctrl
  import nvram_pkg::*;
#(
  parameter int DATA_W          = 4,
  parameter int ADDR_W          = 8,
  parameter bit RECALL_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  input  logic              store_req,
  input  logic              recall_req,
  output logic              busy,
  output logic              done,
  output logic              dirty,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_write,
  input  logic [DATA_W-1:0] host_data,
  output logic [DATA_W-1:0] host_q
);

  localparam int              DEPTH    = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH);

  eng_state_t      r_state;
  logic [ADDR_W:0] r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_dirty;
  logic            r_boot;

  logic [ADDR_W:0]   w_cnt_prev;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_cpu_we;
  logic              w_recall_go;
  logic              w_wk_b_we;
  logic              w_sh_a_we;
  logic [ADDR_W-1:0] w_wk_b_addr;
  logic [ADDR_W-1:0] w_sh_a_addr;
  logic [DATA_W-1:0] w_wk_b_q;
  logic [DATA_W-1:0] w_sh_a_q;
  logic [DATA_W-1:0] w_sh_b_q;
  logic [ADDR_W-1:0] w_host_addr;
  logic              w_host_we;
  logic [DATA_W-1:0] w_host_data;

  assign w_cpu_we    = cpu_write & ~r_busy;
  assign w_recall_go = recall_req | (RECALL_ON_RESET & r_boot);

  // In IDLE r_cnt is 0, so the source word 0 is already prefetched when a request is accepted;
  // the copy then runs cnt = 1..DEPTH writing destination[cnt-1] from the previous read.
  assign w_cnt_prev  = r_cnt - CNT_ONE;
  assign w_rd_addr   = r_cnt[ADDR_W-1:0];
  assign w_wr_addr   = w_cnt_prev[ADDR_W-1:0];

  assign w_wk_b_we   = (r_state == RECALL);
  assign w_sh_a_we   = (r_state == STORE);
  assign w_wk_b_addr = w_wk_b_we ? w_wr_addr : w_rd_addr;
  assign w_sh_a_addr = w_sh_a_we ? w_wr_addr : w_rd_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dirty <= 1'b0;
      r_boot  <= 1'b1;
    end else begin
      // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
      r_boot <= 1'b0;
      r_done <= 1'b0;
      if (w_cpu_we) r_dirty <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_recall_go) begin
            r_state <= RECALL;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end else if (store_req) begin
            r_state <= STORE;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end
        end
        STORE, RECALL: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
            r_dirty <= 1'b0;
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign dirty = r_dirty;

`ifdef NVRAM_HOST_PORT_EN
  assign w_host_addr = host_addr;
  assign w_host_we   = host_write & ~r_busy;
  assign w_host_data = host_data;
  assign host_q      = w_sh_b_q;
`else
  logic w_unused_host;
  assign w_unused_host = ^{host_addr, host_write, host_data, w_sh_b_q};
  assign w_host_addr   = '0;
  assign w_host_we     = 1'b0;
  assign w_host_data   = '0;
  assign host_q        = '0;
`endif

  nvram_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_working (
    .clk       (clk),
    .i_rst     (reset),
    .i_a_addr  (cpu_addr),
    .i_a_write (w_cpu_we),
    .i_a_data  (cpu_data),
    .o_a_q     (cpu_q),
    .i_b_addr  (w_wk_b_addr),
    .i_b_write (w_wk_b_we),
    .i_b_data  (w_sh_a_q),
    .o_b_q     (w_wk_b_q)
  );

  nvram_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_shadow (
    .clk       (clk),
    .i_rst     (reset),
    .i_a_addr  (w_sh_a_addr),
    .i_a_write (w_sh_a_we),
    .i_a_data  (w_wk_b_q),
    .o_a_q     (w_sh_a_q),
    .i_b_addr  (w_host_addr),
    .i_b_write (w_host_we),
    .i_b_data  (w_host_data),
    .o_b_q     (w_sh_b_q)
  );

endmodule

// File: tb/tb_nvram_shadow_ctrl.sv
// Directed self-checking bench for nvram_shadow_ctrl; host-port checks follow NVRAM_HOST_PORT_EN.
module tb_nvram_shadow_ctrl;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 8;
  localparam int COPY_CYCLES = 257;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_data;
  logic [DATA_W-1:0] cpu_q;
  logic              store_req;
  logic              recall_req;
  logic              busy;
  logic              done;
  logic              dirty;
  logic [ADDR_W-1:0] host_addr;
  logic              host_write;
  logic [DATA_W-1:0] host_data;
  logic [DATA_W-1:0] host_q;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nvram_shadow_ctrl #(
    .DATA_W          (DATA_W),
    .ADDR_W          (ADDR_W),
    .RECALL_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_write  (cpu_write),
    .cpu_data   (cpu_data),
    .cpu_q      (cpu_q),
    .store_req  (store_req),
    .recall_req (recall_req),
    .busy       (busy),
    .done       (done),
    .dirty      (dirty),
    .host_addr  (host_addr),
    .host_write (host_write),
    .host_data  (host_data),
    .host_q     (host_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] s_of(input int i);
    logic [31:0] v;
    v = i;
    return v[3:0] ^ 4'h5;
  endfunction

  function automatic logic [DATA_W-1:0] host_exp(input logic [DATA_W-1:0] v);
`ifdef NVRAM_HOST_PORT_EN
    return v;
`else
    return '0;
`endif
  endfunction

  // One cycle on the CPU port; q is the registered read of the addressed word.
  task automatic cpu_op(input logic [ADDR_W-1:0] a, input logic we, input logic [DATA_W-1:0] d,
                        output logic [DATA_W-1:0] q);
    cpu_addr = a; cpu_write = we; cpu_data = d;
    @(negedge clk);
    q = cpu_q;
    cpu_write = 1'b0;
  endtask

  task automatic host_op(input logic [ADDR_W-1:0] a, input logic we, input logic [DATA_W-1:0] d,
                         output logic [DATA_W-1:0] q);
    host_addr = a; host_write = we; host_data = d;
    @(negedge clk);
    q = host_q;
    host_write = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic r);
    store_req = s; recall_req = r;
    @(negedge clk);
    store_req = 1'b0; recall_req = 1'b0;
  endtask

  task automatic wait_done(output int busy_n, output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic full_copy(input string tag, input logic s, input logic r);
    int n;
    bit seen;
    pulse(s, r);
    wait_done(n, seen);
    check({tag, "_done"}, seen, 1);
    check({tag, "_busy_len"}, n, COPY_CYCLES);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_dirty_after"}, dirty, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] q;
    int n;
    bit seen;

    reset = 1'b1;
    cpu_addr = '0; cpu_write = 1'b0; cpu_data = '0;
    store_req = 1'b0; recall_req = 1'b0;
    host_addr = '0; host_write = 1'b0; host_data = '0;

    // Reset values, then the automatic RECALL on reset release.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dirty", dirty, 0);
    check("rst_cpu_q", cpu_q, 0);
    check("rst_host_q", host_q, 0);
    reset = 1'b0;
    @(negedge clk);
    check("boot_recall_busy", busy, 1);
    wait_done(n, seen);
    check("boot_recall_done", seen, 1);
    check("boot_recall_len", n, COPY_CYCLES);
    @(negedge clk);
    check("boot_idle", busy, 0);

    // CPU write / read-back, read-before-write, dirty.
    cpu_op(8'h10, 1'b1, 4'hA, q);
    check("dirty_set", dirty, 1);
    cpu_op(8'h11, 1'b1, 4'h6, q);
    cpu_op(8'h10, 1'b0, 4'h0, q);
    check("cpu_rd_10", q, 4'hA);
    cpu_op(8'h11, 1'b1, 4'h9, q);
    check("cpu_rbw_11", q, 4'h6);
    cpu_op(8'h11, 1'b0, 4'h0, q);
    check("cpu_rd_11", q, 4'h9);

    // STORE, then inspect the shadow through the host port.
    full_copy("store1", 1'b1, 1'b0);
    host_op(8'h10, 1'b0, 4'h0, q);
    check("host_rd_10", q, host_exp(4'hA));

    // Shadow word 0x20 = 5, working 0x20 = C, then RECALL restores 5.
`ifdef NVRAM_HOST_PORT_EN
    host_op(8'h21, 1'b1, 4'h7, q);
    host_op(8'h21, 1'b1, 4'h3, q);
    check("host_rbw_21", q, 4'h7);
    host_op(8'h20, 1'b1, 4'h5, q);
`else
    cpu_op(8'h20, 1'b1, 4'h5, q);
    full_copy("store2", 1'b1, 1'b0);
    host_op(8'h20, 1'b1, 4'h7, q);
    check("host_q_tied", q, 0);
`endif
    cpu_op(8'h20, 1'b1, 4'hC, q);
    check("dirty_before_recall", dirty, 1);
    full_copy("recall1", 1'b0, 1'b1);
    cpu_op(8'h20, 1'b0, 4'h0, q);
    check("recall_rd_20", q, 4'h5);
    cpu_op(8'h10, 1'b0, 4'h0, q);
    check("recall_rd_10", q, 4'hA);

    // Writes during busy are dropped (both issued after the engine has passed those words).
    cpu_op(8'h30, 1'b1, 4'h1, q);
    cpu_op(8'h31, 1'b1, 4'h2, q);
    cpu_op(8'h40, 1'b1, 4'h4, q);
    pulse(1'b1, 1'b0);
    repeat (60) @(negedge clk);
    cpu_op(8'h30, 1'b1, 4'hE, q);
    host_op(8'h31, 1'b1, 4'hD, q);
    wait_done(n, seen);
    check("store3_done", seen, 1);
    @(negedge clk);
    cpu_op(8'h30, 1'b0, 4'h0, q);
    check("busy_cpu_drop", q, 4'h1);
    host_op(8'h31, 1'b0, 4'h0, q);
    check("busy_host_drop", q, host_exp(4'h2));
    check("busy_drop_dirty", dirty, 0);

    // Simultaneous requests: RECALL wins, shadow keeps 4 while working had 8.
    cpu_op(8'h40, 1'b1, 4'h8, q);
    full_copy("both", 1'b1, 1'b1);
    cpu_op(8'h40, 1'b0, 4'h0, q);
    check("both_work_40", q, 4'h4);
    host_op(8'h40, 1'b0, 4'h0, q);
    check("both_shadow_40", q, host_exp(4'h4));

    // Reset in the middle of a RECALL.
    for (int i = 0; i < 256; i++) cpu_op(i[ADDR_W-1:0], 1'b1, s_of(i), q);
    full_copy("store_pat", 1'b1, 1'b0);
    for (int i = 0; i < 256; i++) cpu_op(i[ADDR_W-1:0], 1'b1, 4'hF, q);
    pulse(1'b0, 1'b1);
    repeat (99) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_done_held", done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_reboot_busy", busy, 1);
    cpu_op(8'd200, 1'b0, 4'h0, q);
    check("abort_rd_200", q, 4'hF);
    cpu_op(8'd120, 1'b0, 4'h0, q);
    check("abort_rd_120", q, 4'hF);
    cpu_op(8'd100, 1'b0, 4'h0, q);
    check("abort_rd_100", q, 4'hF);
    cpu_op(8'd97, 1'b0, 4'h0, q);
    check("abort_rd_97", q, s_of(97));
    cpu_op(8'd50, 1'b0, 4'h0, q);
    check("abort_rd_50", q, s_of(50));
    wait_done(n, seen);
    check("reboot_done", seen, 1);
    @(negedge clk);
    cpu_op(8'd200, 1'b0, 4'h0, q);
    check("reboot_rd_200", q, s_of(200));
    cpu_op(8'd120, 1'b0, 4'h0, q);
    check("reboot_rd_120", q, s_of(120));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nvram_shadow_ctrl.md
# nvram_shadow_ctrl

Parametrised non-volatile RAM model for the Star Wars arcade core: a CPU-visible working RAM backed by a shadow array, with X2212-style STORE (working→shadow) and RECALL (shadow→working) block-copy operations. The shadow array is exposed on a host port so the Pocket save-file path can load and unload high scores and settings. It replaces the fixed 256×4 CPU NVRAM with a generic DATA_W×2^ADDR_W store and adds a copy engine, busy/done handshake and dirty tracking.

## Interface
- DATA_W, 4, word width of both arrays
- ADDR_W, 8, address width; depth = 2^ADDR_W
- RECALL_ON_RESET, 1, 1 = start a RECALL automatically on reset release
- clk  in  1  single clock for all ports
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  ADDR_W  CPU working-RAM address
- cpu_write  in  1  CPU write strobe
- cpu_data  in  DATA_W  CPU write data
- cpu_q  out  DATA_W  CPU read data, registered
- store_req  in  1  single-cycle pulse: copy working→shadow
- recall_req  in  1  single-cycle pulse: copy shadow→working
- busy  out  1  copy engine active
- done  out  1  one-cycle pulse at copy completion
- dirty  out  1  working RAM differs from last STORE/RECALL point
- host_addr  in  ADDR_W  host shadow address
- host_write  in  1  host write strobe
- host_data  in  DATA_W  host write data
- host_q  out  DATA_W  host read data, registered

## Operation
- Working RAM: port A CPU, port B copy engine. Shadow: port A copy engine, port B host.
- CPU read: cpu_q <= working[cpu_addr] every cycle; read-before-write (write cycle returns old word).
- CPU write accepted only when busy=0; accepted write sets dirty. Writes while busy are dropped silently.
- Host port: host_q <= shadow[host_addr] every cycle, read-before-write. Host writes accepted only when busy=0; dropped while busy. Host writes do not affect dirty.
- Engine states: IDLE, STORE, RECALL, FINISH.
- IDLE: recall_req → RECALL; else store_req → STORE. Both in same cycle: RECALL wins, store dropped. Requests while not IDLE ignored.
- STORE/RECALL: counter cnt (ADDR_W+1 bits) from 0; each cycle reads source[cnt[ADDR_W-1:0]], writes previous-cycle read data to destination[cnt-1]. Exit to FINISH after write of address 2^ADDR_W−1 (cnt = 2^ADDR_W).
- FINISH: done=1 for one cycle, dirty cleared, → IDLE.
- Reset: state IDLE, cnt 0, busy 0, done 0, dirty 0, cpu_q 0, host_q 0. Array contents NOT cleared (non-volatile). Reset mid-copy aborts; destination holds a partial copy; no done pulse.
- RECALL_ON_RESET=1: first cycle after reset deasserts behaves as recall_req.

## Timing
- cpu_q, host_q: 1-cycle latency from address.
- busy rises the cycle after the accepted request; stays high 2^ADDR_W+1 cycles (includes FINISH); done coincides with last busy cycle.
- Total request→done: 2^ADDR_W+1 cycles (257 at defaults).
- First CPU write accepted the cycle busy is seen low.

## Configuration
- NVRAM_HOST_PORT_EN: defined → host port and shadow port B present as above. Undefined → host_write ignored, host_q tied to 0, shadow reachable only through STORE/RECALL; shadow may be single-port.

## Structure
- Package nvram_pkg: engine state enum (IDLE, STORE, RECALL, FINISH) and depth helper constant.
- Sub-module nvram_dp_ram: parametrised DATA_W×2^ADDR_W dual-port sync RAM, read-before-write on each port; instantiated twice (working, shadow).

## Test plan
- Reset, CPU write 0xA to addr 0x10, read back → cpu_q=0xA one cycle after address; dirty=1.
- store_req pulse → busy for 257 cycles, done pulse, dirty=0; host read addr 0x10 → host_q=0xA.
- Host writes 0x5 to shadow addr 0x20, recall_req → after done, CPU read 0x20 → 0x5, dirty=0.
- CPU write and host write during busy → both dropped; post-copy contents unchanged.
- store_req and recall_req same cycle → RECALL performed (working = shadow), shadow unchanged.
- Assert reset at cnt=100 of a RECALL → busy=0, done never pulses, working[0..98] from shadow, working[≥100] unchanged.
